mem_arbiter: RTL and testbench

//  Responder end of the cache-to-memory bus. Accepts word requests from the icache (read-only)
//  and the dcache (read/write) and serialises them onto the single-ported RAM.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_if.sv | 38 +++
 rtl/mem_arbiter_timeout.sv | 30 +++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the cache-to-memory arbiter: bus word, RAM handshake state
// and the arbiter's grant state.
package mem_arbiter_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DGRANT = 2'b01,
        IGRANT = 2'b10
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side bus of the memory arbiter. The slave modport is the
// arbiter's view; the master modport is the view of the caches plus RAM model.
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    // icache port
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;

    // dcache port
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;

    // RAM port
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter_timeout.sv
// Granted-cycle watchdog: cleared by load, counts enabled cycles and flags
// the terminal count once TIMEOUT cycles have passed without completion.
module mem_arbiter_timeout #(
    parameter int TIMEOUT = 256
) (
    input  logic CLK,
    input  logic nRST,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] count;

    // Count stalled granted cycles; holds at terminal count until reloaded.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == TW'(TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises icache (read) and dcache (read/write) word requests
// onto a single-ported RAM. dcache has fixed priority; every access returns
// to IDLE for one cycle so a dcache block is never split by the icache.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    mem_arbiter_if.slave     bus,
    output logic             err,
    output logic [CNT_W-1:0] icount,
    output logic [CNT_W-1:0] dcount
);

    arb_state_t state;
    arb_state_t next_state;

    logic d_req;
    logic i_req;
    logic ram_access;
    logic ram_error;
    logic i_done;
    logic d_done;
    logic err_set;
    logic timer_load;
    logic timer_en;
    logic timer_tc;

    assign d_req      = bus.dREN | bus.dWEN;
    assign i_req      = bus.iREN;
    assign ram_access = (bus.ramstate == ACCESS);
    assign ram_error  = (bus.ramstate == ERROR);

    mem_arbiter_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .CLK  (CLK),
        .nRST (nRST),
        .load (timer_load),
        .en   (timer_en),
        .tc   (timer_tc)
    );

    // Grant state register; reset drops any in-flight access.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Grant selection, RAM drive from the granted port and completion handling.
    always_comb begin
        next_state   = state;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        i_done       = 1'b0;
        d_done       = 1'b0;
        err_set      = 1'b0;
        timer_load   = 1'b0;
        timer_en     = 1'b0;

        case (state)
            IDLE: begin
                timer_load = 1'b1;
                if (d_req) begin
                    next_state = DGRANT;
                end else if (i_req) begin
                    next_state = IGRANT;
                end
            end

            DGRANT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = bus.dREN & ~bus.dWEN;
                bus.dload    = bus.ramload;
                if (ram_access) begin
                    bus.dwait  = 1'b0;
                    d_done     = 1'b1;
                    next_state = IDLE;
                end else if (ram_error || timer_tc) begin
                    bus.dwait  = 1'b0;
                    bus.dload  = '0;
                    err_set    = 1'b1;
                    next_state = IDLE;
                end else if (!d_req) begin
                    next_state = IDLE;
                end else begin
                    timer_en = 1'b1;
                end
            end

            IGRANT: begin
                bus.ramaddr = bus.iaddr;
                bus.ramREN  = bus.iREN;
                bus.iload   = bus.ramload;
                if (ram_access) begin
                    bus.iwait  = 1'b0;
                    i_done     = 1'b1;
                    next_state = IDLE;
                end else if (ram_error || timer_tc) begin
                    bus.iwait  = 1'b0;
                    bus.iload  = '0;
                    err_set    = 1'b1;
                    next_state = IDLE;
                end else if (!i_req) begin
                    next_state = IDLE;
                end else begin
                    timer_en = 1'b1;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Completed-access counters, wrapping freely.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            icount <= '0;
            dcount <= '0;
        end else begin
            if (i_done) begin
                icount <= icount + 1'b1;
            end
            if (d_done) begin
                dcount <= dcount + 1'b1;
            end
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// single/contending cache requests against a transaction-level reference.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 32;
    localparam int MAXWAIT = 40;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             err;
    logic [CNT_W-1:0] icount;
    logic [CNT_W-1:0] dcount;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .bus    (bus),
        .err    (err),
        .icount (icount),
        .dcount (dcount)
    );

    always #5 CLK = ~CLK;

    // RAM model: fixed latency in enabled cycles, optional forced BUSY/ERROR.
    word_t ramMem [256];
    bit    ramValid [256];
    int    ramLat        = 2;
    bit    ramForceBusy  = 1'b0;
    bit    ramForceError = 1'b0;
    int    ramCnt        = 0;
    logic  ramEn;

    function automatic word_t defaultWord(word_t a);
        return {~a[15:0], a[15:0]};
    endfunction

    assign ramEn = bus.ramREN | bus.ramWEN;

    always_comb begin
        if (!ramEn) bus.ramstate = FREE;
        else if (ramForceError) bus.ramstate = ERROR;
        else if (ramForceBusy) bus.ramstate = BUSY;
        else if (ramCnt >= ramLat - 1) bus.ramstate = ACCESS;
        else bus.ramstate = BUSY;
    end

    always_comb begin
        if (bus.ramREN && bus.ramstate == ACCESS)
            bus.ramload = ramValid[bus.ramaddr[9:2]] ? ramMem[bus.ramaddr[9:2]] : defaultWord(bus.ramaddr);
        else
            bus.ramload = 32'h0BAD_0BAD;
    end

    always @(posedge CLK) begin
        if (ramEn && bus.ramstate != ACCESS) ramCnt <= ramCnt + 1;
        else ramCnt <= 0;
        if (bus.ramWEN && bus.ramstate == ACCESS) begin
            ramMem[bus.ramaddr[9:2]]   <= bus.ramstore;
            ramValid[bus.ramaddr[9:2]] <= 1'b1;
        end
    end

    // Reference model state
    word_t refMem [word_t];
    int    expI = 0;
    int    expD = 0;
    int    total = 0;
    int    bad = 0;

    function automatic word_t refRead(word_t a);
        if (refMem.exists(a)) return refMem[a];
        return defaultWord(a);
    endfunction

    task automatic checkOutput(input string tag, input word_t observed, input word_t expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input bit ire, input word_t ia, input bit dre, input bit dwe,
                                 input word_t da, input word_t ds);
        bus.iREN   = ire;
        bus.iaddr  = ia;
        bus.dREN   = dre;
        bus.dWEN   = dwe;
        bus.daddr  = da;
        bus.dstore = ds;
    endtask

    task automatic doReset();
        nRST = 1'b0;
        nextCycle();
        nextCycle();
        nRST = 1'b1;
        expI = 0;
        expD = 0;
    endtask

    // Present requests in an IDLE cycle (cycle 0) and follow them to completion;
    // each cache drops its request after its wait pulse.
    task automatic runReq(input bit doI, input word_t ia, input bit doDR, input bit doDW,
                          input word_t da, input word_t ds, input int dDropAt,
                          output int dCyc, output word_t dLd, output int iCyc, output word_t iLd,
                          output int dPulses, output int iPulses, output logic [63:0] enMask);
        bit dDrop;
        bit dDone;
        bit iDone;
        dDrop   = 1'b0;
        dCyc    = -1;
        iCyc    = -1;
        dLd     = '0;
        iLd     = '0;
        dPulses = 0;
        iPulses = 0;
        enMask  = '0;
        applyStimulus(doI, ia, doDR, doDW, da, ds);
        for (int c = 0; c < MAXWAIT; c++) begin
            @(negedge CLK);
            enMask[c] = bus.ramREN | bus.ramWEN;
            if (bus.dwait === 1'b0) begin
                dPulses++;
                if (dCyc < 0) begin
                    dCyc = c;
                    dLd  = bus.dload;
                end
            end
            if (bus.iwait === 1'b0) begin
                iPulses++;
                if (iCyc < 0) begin
                    iCyc = c;
                    iLd  = bus.iload;
                end
            end
            nextCycle();
            if (c == dDropAt) dDrop = 1'b1;
            if (dCyc >= 0 || dDrop) begin
                bus.dREN = 1'b0;
                bus.dWEN = 1'b0;
            end
            if (iCyc >= 0) bus.iREN = 1'b0;
            dDone = !(doDR || doDW) || dCyc >= 0 || dDrop;
            iDone = !doI || iCyc >= 0;
            if (dDone && iDone) break;
        end
        checkBit("run_within_budget", (!(doDR || doDW) || dCyc >= 0 || dDrop) && (!doI || iCyc >= 0), 1'b1);
    endtask

    int          dCyc, iCyc, dPulses, iPulses;
    word_t       dLd, iLd;
    logic [63:0] enMask;

    initial begin
        $display("[TB] mem_arbiter bench start");
        nRST = 1'b0;
        applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0);

        // Reset held with requests pending
        nextCycle();
        nextCycle();
        nextCycle();
        @(negedge CLK);
        checkBit("rst_iwait", bus.iwait, 1'b1);
        checkBit("rst_dwait", bus.dwait, 1'b1);
        checkBit("rst_ramREN", bus.ramREN, 1'b0);
        checkBit("rst_ramWEN", bus.ramWEN, 1'b0);
        checkOutput("rst_ramaddr", bus.ramaddr, 32'h0);
        checkOutput("rst_ramstore", bus.ramstore, 32'h0);
        checkOutput("rst_icount", icount, 32'h0);
        checkOutput("rst_dcount", dcount, 32'h0);
        checkBit("rst_err", err, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        nRST = 1'b1;
        nextCycle();

        // Contention, 2-cycle RAM: dcache first, then icache after one idle cycle
        ramLat = 2;
        runReq(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 32'h0, -1, dCyc, dLd, iCyc, iLd, dPulses, iPulses, enMask);
        checkOutput("cont_dcyc", dCyc, 2);
        checkOutput("cont_dload", dLd, refRead(32'h200));
        checkOutput("cont_icyc", iCyc, 5);
        checkOutput("cont_iload", iLd, refRead(32'h100));
        checkOutput("cont_dpulses", dPulses, 1);
        checkOutput("cont_ipulses", iPulses, 1);
        checkBit("cont_idle_gap", enMask[3], 1'b0);
        @(negedge CLK);
        checkOutput("cont_dcount", dcount, 1);
        checkOutput("cont_icount", icount, 1);
        expD = 1;
        expI = 1;
        nextCycle();

        // Two-word dcache writeback while icache keeps requesting
        begin
            int    dp;
            int    iAt;
            int    renSeen;
            word_t pAddr [2];
            word_t pStore [2];
            dp = 0;
            iAt = -1;
            renSeen = 0;
            ramLat = 1;
            applyStimulus(1'b1, 32'h300, 1'b0, 1'b1, 32'h40, 32'hDEAD);
            for (int c = 0; c < MAXWAIT; c++) begin
                @(negedge CLK);
                if (dp < 2 && bus.ramREN === 1'b1) renSeen++;
                if (bus.dwait === 1'b0 && dp < 2) begin
                    pAddr[dp]  = bus.ramaddr;
                    pStore[dp] = bus.ramstore;
                    checkOutput("wb_pulse_cycle", c, (dp == 0) ? 1 : 3);
                    dp++;
                end
                if (bus.iwait === 1'b0 && iAt < 0) iAt = c;
                nextCycle();
                if (dp == 1) begin
                    bus.daddr  = 32'h44;
                    bus.dstore = 32'hBEEF;
                end
                if (dp == 2) bus.dWEN = 1'b0;
                if (iAt >= 0) begin
                    bus.iREN = 1'b0;
                    break;
                end
            end
            checkOutput("wb_dpulses", dp, 2);
            checkOutput("wb_addr0", pAddr[0], 32'h40);
            checkOutput("wb_store0", pStore[0], 32'hDEAD);
            checkOutput("wb_addr1", pAddr[1], 32'h44);
            checkOutput("wb_store1", pStore[1], 32'hBEEF);
            checkOutput("wb_no_ramREN", renSeen, 0);
            checkOutput("wb_icyc", iAt, 5);
            refMem[32'h40] = 32'hDEAD;
            refMem[32'h44] = 32'hBEEF;
            expD += 2;
            expI += 1;
        end
        runReq(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, -1, dCyc, dLd, iCyc, iLd, dPulses, iPulses, enMask);
        checkOutput("wb_readback0", dLd, 32'hDEAD);
        runReq(1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, -1, dCyc, dLd, iCyc, iLd, dPulses, iPulses, enMask);
        checkOutput("wb_readback1", dLd, 32'hBEEF);
        expD += 2;

        // Abort: dcache drops its read before ACCESS, icache then served
        ramLat = 3;
        runReq(1'b1, 32'h84, 1'b1, 1'b0, 32'h80, 32'h0, 1, dCyc, dLd, iCyc, iLd, dPulses, iPulses, enMask);
        checkOutput("abort_dpulses", dPulses, 0);
        checkBit("abort_en_granted", enMask[1], 1'b1);
        checkBit("abort_en_drop", enMask[2], 1'b0);
        checkOutput("abort_icyc", iCyc, 6);
        checkOutput("abort_iload", iLd, refRead(32'h84));
        expI += 1;
        @(negedge CLK);
        checkOutput("abort_dcount", dcount, expD);
        checkOutput("abort_icount", icount, expI);
        nextCycle();

        // Timeout with RAM stuck BUSY
        ramForceBusy = 1'b1;
        runReq(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, -1, dCyc, dLd, iCyc, iLd, dPulses, iPulses, enMask);
        ramForceBusy = 1'b0;
        checkOutput("to_dcyc", dCyc, TIMEOUT + 1);
        checkOutput("to_dload", dLd, 32'h0);
        @(negedge CLK);
        checkBit("to_err", err, 1'b1);
        checkOutput("to_dcount", dcount, expD);
        nextCycle();
        ramLat = 1;
        runReq(1'b1, 32'h24, 1'b0, 1'b0, 32'h0, 32'h0, -1, dCyc, dLd, iCyc, iLd, dPulses, iPulses, enMask);
        nextCycle();
        @(negedge CLK);
        checkBit("to_err_sticky", err, 1'b1);
        nextCycle();
        doReset();
        @(negedge CLK);
        checkBit("to_err_cleared", err, 1'b0);
        nextCycle();

        // RAM ERROR takes the completion path and sets err
        ramForceError = 1'b1;
        runReq(1'b0, 32'h0, 1'b1, 1'b0, 32'h28, 32'h0, -1, dCyc, dLd, iCyc, iLd, dPulses, iPulses, enMask);
        ramForceError = 1'b0;
        checkOutput("rerr_dcyc", dCyc, 1);
        checkOutput("rerr_dload", dLd, 32'h0);
        @(negedge CLK);
        checkBit("rerr_err", err, 1'b1);
        checkOutput("rerr_dcount", dcount, 32'h0);
        nextCycle();
        doReset();

        // Mid-access reset during IGRANT
        ramForceBusy = 1'b1;
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge CLK);
        nextCycle();
        @(negedge CLK);
        checkBit("mid_granted_ren", bus.ramREN, 1'b1);
        checkBit("mid_granted_iwait", bus.iwait, 1'b1);
        nextCycle();
        nRST = 1'b0;
        @(negedge CLK);
        checkBit("mid_iwait_during_rst", bus.iwait, 1'b1);
        nextCycle();
        nRST = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        ramForceBusy = 1'b0;
        @(negedge CLK);
        checkBit("mid_ren_low", bus.ramREN, 1'b0);
        checkBit("mid_iwait_high", bus.iwait, 1'b1);
        checkOutput("mid_ramaddr", bus.ramaddr, 32'h0);
        checkOutput("mid_icount", icount, 32'h0);
        expI = 0;
        expD = 0;
        nextCycle();

        // Random traffic against the transaction-level reference
        for (int n = 0; n < 40; n++) begin
            int    lat;
            int    kind;
            bit    doI;
            bit    doD;
            bit    doDR;
            bit    doDW;
            word_t ia;
            word_t da;
            word_t ds;
            lat  = $urandom_range(1, 4);
            kind = $urandom_range(0, 3);
            doI  = (kind >= 2);
            doD  = (kind != 2);
            doDW = doD && ($urandom_range(0, 1) == 1);
            doDR = doD && (doDW ? ($urandom_range(0, 1) == 1) : 1'b1);
            ia   = 32'h200 + ($urandom_range(0, 15) << 2);
            da   = 32'h200 + ($urandom_range(0, 15) << 2);
            ds   = $urandom;
            ramLat = lat;
            runReq(doI, ia, doDR, doDW, da, ds, -1, dCyc, dLd, iCyc, iLd, dPulses, iPulses, enMask);
            if (doD) begin
                checkOutput("rnd_dcyc", dCyc, lat);
                checkOutput("rnd_dpulses", dPulses, 1);
                if (!doDW) checkOutput("rnd_dload", dLd, refRead(da));
                else refMem[da] = ds;
                expD++;
            end else begin
                checkOutput("rnd_no_dpulse", dPulses, 0);
            end
            if (doI) begin
                checkOutput("rnd_icyc", iCyc, doD ? 2 * lat + 1 : lat);
                checkOutput("rnd_iload", iLd, refRead(ia));
                checkOutput("rnd_ipulses", iPulses, 1);
                expI++;
            end
        end
        @(negedge CLK);
        checkOutput("rnd_icount", icount, expI);
        checkOutput("rnd_dcount", dcount, expD);
        checkBit("rnd_err", err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
